// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner encodings and width defaults for the data-RAM arbiter
package mem_arb_pkg;
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;
  typedef enum logic {IDLE, RD_WAIT} state_e;
  typedef enum logic {OWN_P0 = 1'b0, OWN_P1 = 1'b1} owner_e;
endpackage

// File: rtl/mem_arbiter_arb_grant.sv
// arb_grant: 2-way grant, fixed p0 > p1 priority, or round-robin when MEM_ARB_RR_EN is defined
module arb_grant
  import mem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
`ifdef MEM_ARB_RR_EN
  input  logic rr_last_i,
`endif
  output logic gnt0_o,
  output logic gnt1_o
);
`ifdef MEM_ARB_RR_EN
  // On contention favour whichever requester was not granted last
  always_comb begin
    gnt0_o = req0_i & (~req1_i | (rr_last_i == OWN_P1));
    gnt1_o = req1_i & (~req0_i | (rr_last_i == OWN_P0));
  end
`else
  // p0 always wins contention
  always_comb begin
    gnt0_o = req0_i;
    gnt1_o = req1_i & ~req0_i;
  end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port data RAM between the MEM stage (p0) and the loader (p1); MEM_ARB_RR_EN enables round-robin
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  localparam logic [1:0] LAT = 2'(RD_LAT);
  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [1:0]    lat_q, lat_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] rd0_q, rd1_q;
  logic          idle, req0, req1, g0, g1, rv0, rv1;
  assign idle = state_q == IDLE;
  // Grants are only possible in IDLE and are forced low while reset is held
  assign req0 = p0_req & rst & idle;
  assign req1 = p1_req & rst & idle;
`ifdef MEM_ARB_RR_EN
  owner_e rr_q, rr_d;
  assign rr_d = g1 ? OWN_P1 : g0 ? OWN_P0 : rr_q;
  // Remember who was granted last for round-robin tie-breaking
  always_ff @(posedge clk or negedge rst)
    if (!rst) rr_q <= OWN_P1;
    else rr_q <= rr_d;
  arb_grant u_grant (.req0_i(req0), .req1_i(req1), .rr_last_i(rr_q), .gnt0_o(g0), .gnt1_o(g1));
`else
  arb_grant u_grant (.req0_i(req0), .req1_i(req1), .gnt0_o(g0), .gnt1_o(g1));
`endif
  assign rv0 = (state_q == RD_WAIT) && (lat_q == 2'd1) && (owner_q == OWN_P0);
  assign rv1 = (state_q == RD_WAIT) && (lat_q == 2'd1) && (owner_q == OWN_P1);
  assign p0_gnt    = g0;
  assign p1_gnt    = g1;
  assign p0_rvalid = rv0;
  assign p1_rvalid = rv1;
  assign p0_rdata  = rv0 ? ram_rdata : rd0_q;
  assign p1_rdata  = rv1 ? ram_rdata : rd1_q;
  // RAM mux from the granted requester in IDLE; hold the read address while waiting on RAM latency
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_d     = lat_q;
    addr_d    = addr_q;
    ram_we    = 1'b0;
    ram_addr  = idle ? '0 : addr_q;
    ram_wdata = '0;
    if (idle) begin
      ram_addr  = g1 ? p1_addr : g0 ? p0_addr : '0;
      ram_wdata = g1 ? p1_wdata : g0 ? p0_wdata : '0;
      ram_we    = (g0 & p0_we) | (g1 & p1_we);
      if ((g0 & ~p0_we) | (g1 & ~p1_we)) begin
        state_d = RD_WAIT;
        owner_d = g1 ? OWN_P1 : OWN_P0;
        lat_d   = LAT;
        addr_d  = ram_addr;
      end
    end else begin
      lat_d   = lat_q - 2'd1;
      state_d = (lat_q == 2'd1) ? IDLE : RD_WAIT;
    end
  end
  // FSM, latency counter, latched read address and per-port read data holding registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_P0;
      lat_q   <= '0;
      addr_q  <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      rd0_q   <= rv0 ? ram_rdata : rd0_q;
      rd1_q   <= rv1 ? ram_rdata : rd1_q;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, directed corner sequences and random traffic against a transaction-level model
module tb_mem_arbiter;
  localparam int RD_LAT = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [9:0] p0_addr = 0, p1_addr = 0;
  logic [31:0] p0_wdata = 0, p1_wdata = 0;
  logic p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, ram_we;
  logic [31:0] p0_rdata, p1_rdata, ram_wdata, ram_rdata;
  logic [9:0] ram_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(10), .DW(32), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Synchronous-read RAM with RD_LAT cycles of read latency
  logic [31:0] mem [1024];
  logic [31:0] rq [RD_LAT];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rq[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) rq[i] <= rq[i-1];
  end
  assign ram_rdata = rq[RD_LAT-1];

  logic dg [2], dv [2];
  logic [31:0] dr [2];
  assign dg[0] = p0_gnt;    assign dg[1] = p1_gnt;
  assign dv[0] = p0_rvalid; assign dv[1] = p1_rvalid;
  assign dr[0] = p0_rdata;  assign dr[1] = p1_rdata;

  int checks = 0, errors = 0;
  int n = 0, busy_until = -1, rv_at = -1, rv_port = 0;
  logic [31:0] rv_data = 0;
  logic [9:0] rd_addr = 0;
  logic [31:0] held [2];
  bit known [2];
  logic [31:0] mm [1024];
  bit wr [1024];
  bit pr [2], pw [2];
  logic [9:0] pa [2] = '{0, 0};
  logic [31:0] pd [2] = '{0, 0};
  int obs_g [2] = '{-1, -1};
  int obs_v [2] = '{-1, -1};
  int dseq [$];
`ifdef MEM_ARB_RR_EN
  int m_rr = 1;
`endif

  typedef struct {
    logic r0, w0; logic [9:0] a0; logic [31:0] d0;
    logic r1, w1; logic [9:0] a1; logic [31:0] d1;
    logic g0, g1, we; logic [9:0] ad; logic [31:0] wd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, n, act, exp);
    end
  endtask

  task automatic req(input int p, input bit we, input logic [9:0] a, input logic [31:0] d);
    pr[p] = 1; pw[p] = we; pa[p] = a; pd[p] = d;
  endtask

  // One clock of traffic: drive held requests, compare against the model, then advance it
  task automatic cycle();
    int win;
    bit free, ev;
    @(negedge clk);
    p0_req = pr[0]; p0_we = pw[0]; p0_addr = pa[0]; p0_wdata = pd[0];
    p1_req = pr[1]; p1_we = pw[1]; p1_addr = pa[1]; p1_wdata = pd[1];
    #1;
    free = n > busy_until;
    win = -1;
    if (free && (pr[0] || pr[1]))
`ifdef MEM_ARB_RR_EN
      win = (pr[0] && pr[1]) ? (m_rr == 1 ? 0 : 1) : (pr[1] ? 1 : 0);
`else
      win = pr[0] ? 0 : 1;
`endif
    chk("p0_gnt", {31'd0, p0_gnt}, {31'd0, win == 0});
    chk("p1_gnt", {31'd0, p1_gnt}, {31'd0, win == 1});
    chk("ram_we", {31'd0, ram_we}, (win >= 0) ? {31'd0, pw[win]} : 32'd0);
    if (win >= 0) begin
      chk("ram_addr", {22'd0, ram_addr}, {22'd0, pa[win]});
      if (pw[win]) chk("ram_wdata", ram_wdata, pd[win]);
    end else if (!free) chk("ram_addr_hold", {22'd0, ram_addr}, {22'd0, rd_addr});
    for (int p = 0; p < 2; p++) begin
      ev = (n == rv_at) && (rv_port == p);
      chk($sformatf("p%0d_rvalid", p), {31'd0, dv[p]}, {31'd0, ev});
      if (ev) begin held[p] = rv_data; known[p] = 1; end
      if (known[p]) chk($sformatf("p%0d_rdata", p), dr[p], held[p]);
      if (dg[p]) begin obs_g[p] = n; dseq.push_back(p); end
      if (dv[p]) obs_v[p] = n;
    end
    if (win >= 0) begin
`ifdef MEM_ARB_RR_EN
      m_rr = win;
`endif
      if (pw[win]) begin
        mm[pa[win]] = pd[win];
        wr[pa[win]] = 1;
      end else begin
        busy_until = n + RD_LAT;
        rv_at = n + RD_LAT;
        rv_port = win;
        rv_data = mm[pa[win]];
        rd_addr = pa[win];
      end
      pr[win] = 0;
    end
    n++;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && (pr[0] || pr[1] || n <= busy_until); k++) cycle();
    chk("drain_idle", {31'd0, pr[0] | pr[1]}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d", n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tv [8];
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_p0_gnt", {31'd0, p0_gnt}, 32'd0);
    chk("rst_p1_gnt", {31'd0, p1_gnt}, 32'd0);
    chk("rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
    chk("rst_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    rst = 1'b1;

    tv[0] = '{0, 0, 10'h000, 32'h0,        0, 0, 10'h000, 32'h0,        0, 0, 0, 10'h000, 32'h0};
    tv[1] = '{1, 1, 10'h005, 32'hDEADBEEF, 0, 0, 10'h000, 32'h0,        1, 0, 1, 10'h005, 32'hDEADBEEF};
    tv[2] = '{0, 0, 10'h000, 32'h0,        1, 1, 10'h3FE, 32'hA1,       0, 1, 1, 10'h3FE, 32'hA1};
    tv[3] = '{0, 0, 10'h000, 32'h0,        1, 1, 10'h3FF, 32'hA2,       0, 1, 1, 10'h3FF, 32'hA2};
    tv[4] = '{0, 0, 10'h000, 32'h0,        1, 1, 10'h000, 32'hA3,       0, 1, 1, 10'h000, 32'hA3};
    tv[5] = '{1, 1, 10'h010, 32'h11111111, 1, 1, 10'h020, 32'h22222222, 1, 0, 1, 10'h010, 32'h11111111};
    tv[6] = '{0, 0, 10'h000, 32'h0,        1, 1, 10'h020, 32'h22222222, 0, 1, 1, 10'h020, 32'h22222222};
    tv[7] = '{1, 1, 10'h030, 32'h33333333, 0, 0, 10'h000, 32'h0,        1, 0, 1, 10'h030, 32'h33333333};
    foreach (tv[i]) begin
      @(negedge clk);
      p0_req = tv[i].r0; p0_we = tv[i].w0; p0_addr = tv[i].a0; p0_wdata = tv[i].d0;
      p1_req = tv[i].r1; p1_we = tv[i].w1; p1_addr = tv[i].a1; p1_wdata = tv[i].d1;
      #1;
      chk($sformatf("tv%0d_p0_gnt", i), {31'd0, p0_gnt}, {31'd0, tv[i].g0});
      chk($sformatf("tv%0d_p1_gnt", i), {31'd0, p1_gnt}, {31'd0, tv[i].g1});
      chk($sformatf("tv%0d_ram_we", i), {31'd0, ram_we}, {31'd0, tv[i].we});
      if (tv[i].g0 | tv[i].g1) begin
        chk($sformatf("tv%0d_ram_addr", i), {22'd0, ram_addr}, {22'd0, tv[i].ad});
        chk($sformatf("tv%0d_ram_wdata", i), ram_wdata, tv[i].wd);
      end
      if (tv[i].g0) begin mm[tv[i].a0] = tv[i].d0; wr[tv[i].a0] = 1; end
      if (tv[i].g1) begin mm[tv[i].a1] = tv[i].d1; wr[tv[i].a1] = 1; end
`ifdef MEM_ARB_RR_EN
      if (tv[i].g0) m_rr = 0;
      if (tv[i].g1) m_rr = 1;
`endif
      n++;
    end

    req(0, 0, 10'h005, 0);
    drain();
    chk("a_p0_rdata", p0_rdata, 32'hDEADBEEF);
    chk("a_rd_latency", obs_v[0] - obs_g[0], RD_LAT);

    req(1, 1, 10'h040, 32'h44);
    drain();
    req(0, 0, 10'h010, 0);
    req(1, 0, 10'h020, 0);
    drain();
    chk("b_p1_gnt_after_p0_rvalid", obs_g[1], obs_v[0] + 1);
    chk("b_p0_rdata", p0_rdata, 32'h11111111);
    chk("b_p1_rdata", p1_rdata, 32'h22222222);

    req(0, 0, 10'h030, 0);
    cycle();
    req(1, 1, 10'h050, 32'h55555555);
    drain();
    chk("c_p1_wr_after_rd", obs_g[1], obs_v[0] + 1);
    req(1, 0, 10'h050, 0);
    drain();
    chk("c_readback", p1_rdata, 32'h55555555);

    req(1, 1, 10'h060, 32'h66);
    drain();
    dseq.delete();
    for (int k = 0; k < 80 && dseq.size() < 8; k++) begin
      if (!pr[0]) req(0, 0, 10'h010, 0);
      if (!pr[1]) req(1, 0, 10'h020, 0);
      cycle();
    end
    drain();
    chk("d_grant_count", {31'd0, dseq.size() >= 8}, 32'd1);
    for (int i = 0; i < 8 && i < dseq.size(); i++)
`ifdef MEM_ARB_RR_EN
      chk($sformatf("d_owner%0d", i), dseq[i], i % 2);
`else
      chk($sformatf("d_owner%0d", i), dseq[i], 0);
`endif

    req(1, 0, 10'h3FE, 0); drain();
    chk("e_rd_3fe", p1_rdata, 32'hA1);
    req(1, 0, 10'h3FF, 0); drain();
    chk("e_rd_3ff", p1_rdata, 32'hA2);
    req(1, 0, 10'h000, 0); drain();
    chk("e_rd_000", p1_rdata, 32'hA3);

    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < 2; p++)
        if (!pr[p] && $urandom_range(0, 2) == 0) begin
          logic [9:0] a;
          bit we;
          a = 10'($urandom_range(0, 31));
          we = 1'($urandom_range(0, 1));
          if (!wr[a]) we = 1;
          req(p, we, a, $urandom);
        end
      cycle();
    end
    drain();

    req(0, 0, 10'h005, 0);
    cycle();
    cycle();
    @(negedge clk);
    rst = 1'b0;
    p0_req = 1; p0_we = 0; p1_req = 1; p1_we = 1;
    #1;
    chk("f_p0_gnt", {31'd0, p0_gnt}, 32'd0);
    chk("f_p1_gnt", {31'd0, p1_gnt}, 32'd0);
    chk("f_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
    chk("f_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
    chk("f_ram_we", {31'd0, ram_we}, 32'd0);
    @(negedge clk);
    p0_req = 0; p1_req = 0;
    rst = 1'b1;
    busy_until = -1; rv_at = -1;
    known[0] = 0; known[1] = 0;
    pr[0] = 0; pr[1] = 0;
`ifdef MEM_ARB_RR_EN
    m_rr = 1;
`endif
    repeat (RD_LAT + 3) cycle();
    req(1, 0, 10'h3FE, 0);
    drain();
    chk("f_post_reset_read", p1_rdata, 32'hA1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
